// File: rtl/cmp_sort_ctrl.sv
// cmp_sort_ctrl: sequencing controller for one shared signed magnitude comparator.
// Loads a burst of N signed values, bubble-sorts them in place by issuing one
// compare per cycle to an external comparator, then streams the result out.
// Optional feature macro: CMP_SORT_EARLY_EXIT_EN (stop sorting after a pass
// that performed no swap).
module cmp_sort_ctrl #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    input  logic         desc,
    output logic [W-1:0] cmp_a,
    output logic [W-1:0] cmp_b,
    output logic         cmp_en,
    input  logic         cmp_gt,
    input  logic         cmp_eq,
    input  logic         cmp_lt,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         done,
    output logic         cmp_err
);

    // Counter width wide enough to index every entry (N >= 2).
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } ctrlState;

    ctrlState       state;

    // Entry storage. Needs two simultaneous reads plus a two-entry swap per
    // cycle, so it is kept in flops rather than a block RAM.
    logic [W-1:0]   mem     [N];
    logic [W-1:0]   memNext [N];

    logic [CW-1:0]  loadCnt;
    logic [CW-1:0]  passIdx;
    logic [CW-1:0]  cmpIdx;
    logic [CW-1:0]  cmpNextIdx;
    logic [CW-1:0]  lastIdx;
    logic [CW-1:0]  drainIdx;
    logic           descLatch;

    logic           inReadyQ;
    logic           cmpEnQ;
    logic           outValidQ;
    logic           cmpErrQ;

    logic           loadFire;
    logic           drainFire;
    logic           lastDrain;
    logic           resultOk;
    logic           wantSwap;
    logic           doSwap;
    logic           lastInPass;
    logic           lastPass;
    logic           sortFinished;

`ifdef CMP_SORT_EARLY_EXIT_EN
    // Set once any compare of the current pass has swapped.
    logic           passSwapped;
`endif

    // Handshakes and compare decode, all derived from registered state.
    assign loadFire   = inReadyQ & in_valid;
    assign drainFire  = outValidQ & out_ready;
    assign lastDrain  = (drainIdx == CW'(N - 1));

    assign cmpNextIdx = cmpIdx + 1'b1;
    assign lastIdx    = CW'(N - 2) - passIdx;
    assign lastInPass = (cmpIdx == lastIdx);
    assign lastPass   = (passIdx == CW'(N - 2));

    // A trustworthy comparator reports exactly one relation.
    assign resultOk   = $onehot({cmp_gt, cmp_eq, cmp_lt});
    // Equal operands never swap, which keeps the sort stable.
    assign wantSwap   = descLatch ? cmp_lt : cmp_gt;
    assign doSwap     = cmpEnQ & resultOk & wantSwap;

`ifdef CMP_SORT_EARLY_EXIT_EN
    assign sortFinished = lastInPass & (lastPass | ~(passSwapped | doSwap));
`else
    assign sortFinished = lastInPass & lastPass;
`endif

    // Outputs: flags come straight from registers; operands and drain data
    // are registered-index reads, forced to zero outside their state.
    assign in_ready  = inReadyQ;
    assign cmp_en    = cmpEnQ;
    assign out_valid = outValidQ;
    assign cmp_err   = cmpErrQ;
    assign cmp_a     = cmpEnQ ? mem[cmpIdx] : '0;
    assign cmp_b     = cmpEnQ ? mem[cmpNextIdx] : '0;
    assign out_data  = outValidQ ? mem[drainIdx] : '0;
    assign done      = drainFire & lastDrain;

    // Next contents of the entry store: load write or compare-driven swap.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            memNext[i] = mem[i];
        end
        if (loadFire) begin
            memNext[loadCnt] = in_data;
        end
        if (doSwap) begin
            memNext[cmpIdx]     = mem[cmpNextIdx];
            memNext[cmpNextIdx] = mem[cmpIdx];
        end
    end

    // Entry store register; cleared on reset so an aborted burst leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= memNext[i];
            end
        end
    end

    // Main sequencer: LOAD -> SORT -> DRAIN -> LOAD with registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            loadCnt   <= '0;
            passIdx   <= '0;
            cmpIdx    <= '0;
            drainIdx  <= '0;
            descLatch <= 1'b0;
            inReadyQ  <= 1'b1;
            cmpEnQ    <= 1'b0;
            outValidQ <= 1'b0;
            cmpErrQ   <= 1'b0;
`ifdef CMP_SORT_EARLY_EXIT_EN
            passSwapped <= 1'b0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    if (loadFire) begin
                        // Sort order is fixed by the first value of the burst.
                        if (loadCnt == '0) begin
                            descLatch <= desc;
                        end
                        if (loadCnt == CW'(N - 1)) begin
                            loadCnt  <= '0;
                            passIdx  <= '0;
                            cmpIdx   <= '0;
                            inReadyQ <= 1'b0;
                            cmpEnQ   <= 1'b1;
                            state    <= SORT;
`ifdef CMP_SORT_EARLY_EXIT_EN
                            passSwapped <= 1'b0;
`endif
                        end else begin
                            loadCnt <= loadCnt + 1'b1;
                        end
                    end
                end

                SORT: begin
                    // A malformed result is flagged but sequencing carries on.
                    if (!resultOk) begin
                        cmpErrQ <= 1'b1;
                    end
                    if (sortFinished) begin
                        cmpIdx    <= '0;
                        passIdx   <= '0;
                        drainIdx  <= '0;
                        cmpEnQ    <= 1'b0;
                        outValidQ <= 1'b1;
                        state     <= DRAIN;
                    end else if (lastInPass) begin
                        passIdx <= passIdx + 1'b1;
                        cmpIdx  <= '0;
                    end else begin
                        cmpIdx <= cmpIdx + 1'b1;
                    end
`ifdef CMP_SORT_EARLY_EXIT_EN
                    if (lastInPass) begin
                        passSwapped <= 1'b0;
                    end else begin
                        passSwapped <= passSwapped | doSwap;
                    end
`endif
                end

                DRAIN: begin
                    if (drainFire) begin
                        if (lastDrain) begin
                            drainIdx  <= '0;
                            outValidQ <= 1'b0;
                            inReadyQ  <= 1'b1;
                            state     <= LOAD;
                        end else begin
                            drainIdx <= drainIdx + 1'b1;
                        end
                    end
                end

                default: begin
                    state     <= LOAD;
                    inReadyQ  <= 1'b1;
                    cmpEnQ    <= 1'b0;
                    outValidQ <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Testbench for cmp_sort_ctrl: table-driven bursts, hand-written corner
// sequences (mid-sort reset, bad comparator result) and random bursts checked
// against a behavioural sorting model. A comparator model sits beside the DUT.
module tb_cmp_sort_ctrl;

    localparam int N = 4;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         desc = 1'b0;
    logic [W-1:0] cmp_a;
    logic [W-1:0] cmp_b;
    logic         cmp_en;
    logic         cmp_gt;
    logic         cmp_eq;
    logic         cmp_lt;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;
    logic         done;
    logic         cmp_err;
    logic         badInject = 1'b0;

    int total = 0;
    int bad   = 0;

    cmp_sort_ctrl #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .desc      (desc),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .cmp_en    (cmp_en),
        .cmp_gt    (cmp_gt),
        .cmp_eq    (cmp_eq),
        .cmp_lt    (cmp_lt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .done      (done),
        .cmp_err   (cmp_err)
    );

    always #5 clk = ~clk;

    // External signed comparator, with an injectable illegal result.
    assign cmp_gt = badInject ? 1'b1 : ($signed(cmp_a) > $signed(cmp_b));
    assign cmp_lt = badInject ? 1'b1 : ($signed(cmp_a) < $signed(cmp_b));
    assign cmp_eq = badInject ? 1'b0 : (cmp_a == cmp_b);

    typedef struct packed {
        logic [15:0] v;     // four nibbles, first loaded in [15:12]
        logic        d;
        logic        mode;  // 0: out_ready held high, 1: pattern 1,0,0,1
        logic [15:0] e;
        logic [3:0]  cyc;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int nib(input logic [15:0] v, input int i);
        logic [3:0] t;
        t = v[15-4*i -: 4];
        return int'($signed(t));
    endfunction

    function automatic logic readyFor(input logic mode, input int c);
        if (!mode) return 1'b1;
        return ((c % 4) == 0) || ((c % 4) == 3);
    endfunction

    // Reference: sorted order by value, and how many compares the schedule spends.
    function automatic void refSort(input logic [15:0] v, input logic d,
                                    output logic [15:0] e, output int cyc);
        int a [4];
        int b [4];
        int t;
        bit sw;
        for (int i = 0; i < 4; i++) begin
            a[i] = nib(v, i);
            b[i] = a[i];
        end
        for (int i = 1; i < 4; i++) begin
            for (int j = i; j > 0 && (d ? a[j] > a[j-1] : a[j] < a[j-1]); j--) begin
                t = a[j]; a[j] = a[j-1]; a[j-1] = t;
            end
        end
        e = '0;
        for (int i = 0; i < 4; i++) begin
            t = a[i];
            e[15-4*i -: 4] = t[3:0];
        end
`ifdef CMP_SORT_EARLY_EXIT_EN
        cyc = 0;
        for (int p = 0; p < 3; p++) begin
            sw = 0;
            for (int j = 0; j < 3 - p; j++) begin
                cyc++;
                if (d ? (b[j] < b[j+1]) : (b[j] > b[j+1])) begin
                    t = b[j]; b[j] = b[j+1]; b[j+1] = t;
                    sw = 1;
                end
            end
            if (!sw) break;
        end
`else
        sw = 0;
        cyc = N * (N - 1) / 2;
`endif
    endfunction

    // Starts and ends at posedge+1. desc is flipped after the first value to
    // show it is only sampled on the first handshake.
    task automatic loadBurst(input logic [15:0] v, input logic d);
        bit hs;
        int g;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = v[15-4*i -: 4];
            desc     = (i == 0) ? d : ~d;
            hs = 0;
            g  = 0;
            while (!hs && g < 100) begin
                @(negedge clk);
                hs = in_ready;
                @(posedge clk);
                #1;
                g++;
            end
            if (!hs) chk("load_timeout", 0, 1);
        end
        in_valid = 1'b0;
        in_data  = '0;
        desc     = 1'b0;
    endtask

    // Counts SORT cycles; returns at the negedge of the first DRAIN cycle.
    task automatic measureSort(output int cyc);
        int g;
        bit first;
        cyc = 0;
        g = 0;
        first = 1;
        in_valid = 1'b1;      // must be ignored outside LOAD
        in_data  = 4'h5;
        while (g < 200) begin
            @(negedge clk);
            if (out_valid) break;
            if (cmp_en) begin
                if (first) begin
                    chk("in_ready_in_sort", int'(in_ready), 0);
                    first = 0;
                end
                cyc++;
            end
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 200) chk("sort_timeout", 0, 1);
    endtask

    // Starts at the negedge of the first DRAIN cycle; ends at posedge+1.
    task automatic drainBurst(input logic mode, output logic [15:0] got);
        int k;
        int c;
        int doneCnt;
        bit prevStall;
        logic [3:0] held;
        k = 0;
        c = 0;
        doneCnt = 0;
        prevStall = 0;
        held = '0;
        got = '0;
        in_valid = 1'b0;
        in_data  = '0;
        while (k < 4 && c < 200) begin
            if (done) doneCnt++;
            chk("drain_valid", int'(out_valid), 1);
            chk("done_pulse", int'(done), int'(out_ready && k == 3));
            if (prevStall) chk("hold_data", int'(out_data), int'(held));
            if (out_ready) begin
                got[15-4*k -: 4] = out_data;
                k++;
                prevStall = 0;
            end else begin
                prevStall = 1;
                held = out_data;
            end
            @(posedge clk);
            #1;
            c++;
            out_ready = readyFor(mode, c);
            if (k < 4) @(negedge clk);
        end
        if (k < 4) chk("drain_timeout", k, 4);
        @(negedge clk);
        chk("post_done_valid", int'(out_valid), 0);
        chk("post_done_ready", int'(in_ready), 1);
        chk("post_done_done", int'(done), 0);
        chk("done_count", doneCnt, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic runBurst(input int id, input logic [15:0] v, input logic d,
                            input logic mode, input logic [15:0] e, input int expCyc);
        logic [15:0] got;
        int cyc;
        loadBurst(v, d);
        out_ready = readyFor(mode, 0);
        measureSort(cyc);
        chk($sformatf("b%0d_sort_cycles", id), cyc, expCyc);
        drainBurst(mode, got);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b%0d_out%0d", id, i), nib(got, i), nib(e, i));
        end
        $display("burst %0d: in=%h desc=%0d ready_mode=%0d out=%h exp=%h sort_cycles=%0d",
                 id, v, d, mode, got, e, cyc);
    endtask

    initial begin
        logic [15:0] e;
        logic [15:0] v;
        logic [15:0] got;
        logic [3:0]  t;
        logic        d;
        int          cyc;
        int          n;
        int          g;

        tbl[0] = '{v: 16'h3E78, d: 1'b0, mode: 1'b0, e: 16'h8E37, cyc: 4'd6};
        tbl[1] = '{v: 16'h3E78, d: 1'b1, mode: 1'b0, e: 16'h73E8, cyc: 4'd6};
`ifdef CMP_SORT_EARLY_EXIT_EN
        tbl[2] = '{v: 16'h8F07, d: 1'b0, mode: 1'b0, e: 16'h8F07, cyc: 4'd3};
`else
        tbl[2] = '{v: 16'h8F07, d: 1'b0, mode: 1'b0, e: 16'h8F07, cyc: 4'd6};
`endif
        tbl[3] = '{v: 16'h55FF, d: 1'b0, mode: 1'b1, e: 16'hFF55, cyc: 4'd6};

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cmp_en", int'(cmp_en), 0);
        chk("rst_cmp_err", int'(cmp_err), 0);
        chk("rst_cmp_a", int'(cmp_a), 0);
        chk("rst_cmp_b", int'(cmp_b), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Table-driven bursts
        for (int i = 0; i < 4; i++) begin
            runBurst(i, tbl[i].v, tbl[i].d, tbl[i].mode, tbl[i].e, int'(tbl[i].cyc));
        end

        // Reset during the third SORT cycle aborts the burst
        loadBurst(16'h3E78, 1'b0);
        n = 0;
        g = 0;
        while (n < 3 && g < 100) begin
            @(negedge clk);
            if (cmp_en) n++;
            if (n < 3) begin
                @(posedge clk);
                #1;
            end
            g++;
        end
        chk("reset_reach_sort3", n, 3);
        rst_n = 1'b0;
        #1;
        chk("midrst_cmp_en", int'(cmp_en), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_cmp_a", int'(cmp_a), 0);
        chk("midrst_cmp_b", int'(cmp_b), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_no_output", int'(out_valid), 0);
        @(posedge clk);
        #1;
        refSort(16'h102D, 1'b0, e, cyc);
        runBurst(10, 16'h102D, 1'b0, 1'b0, 16'hD012, cyc);

        // Random bursts against the reference model
        for (int r = 0; r < 16; r++) begin
            v = '0;
            for (int i = 0; i < 4; i++) begin
                t = 4'($urandom_range(0, 15));
                v[15-4*i -: 4] = t;
            end
            d = 1'($urandom_range(0, 1));
            refSort(v, d, e, cyc);
            runBurst(20 + r, v, d, 1'($urandom_range(0, 1)), e, cyc);
        end

        // Illegal comparator result on the first SORT cycle
        loadBurst(16'h3E78, 1'b0);
        badInject = 1'b1;
        @(negedge clk);
        chk("bad_c1_cmp_a", int'(cmp_a), 3);
        chk("bad_c1_err_before", int'(cmp_err), 0);
        @(posedge clk);
        #1;
        badInject = 1'b0;
        @(negedge clk);
        chk("bad_err_set", int'(cmp_err), 1);
        chk("bad_noswap_a", int'($signed(cmp_a)), -2);
        chk("bad_noswap_b", int'($signed(cmp_b)), 7);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        measureSort(cyc);
        chk("bad_sort_cycles", cyc + 2, 6);
        drainBurst(1'b0, got);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bad_out%0d", i), nib(got, i), nib(16'h8E37, i));
        end
        $display("burst 40: in=3e78 desc=0 bad compare injected out=%h cmp_err=%0d", got, cmp_err);
        chk("bad_err_sticky", int'(cmp_err), 1);
        refSort(16'h102D, 1'b1, e, cyc);
        runBurst(41, 16'h102D, 1'b1, 1'b1, e, cyc);
        chk("bad_err_sticky2", int'(cmp_err), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cmp_sort_ctrl.md
Name: cmp_sort_ctrl

Overview:
- Sequencing controller for one shared 4-bit signed magnitude comparator.
- Accepts a burst of N signed 4-bit values and sorts them in place with a bubble-sort schedule.
- Issues one compare per cycle to an external comparator instance, then streams the sorted values out.
- Sits between a producer/consumer pair and the comparator datapath, which is instantiated beside it, not inside it.

Parameters:
- N, 4, number of entries per burst; legal range 2..8.
- W, 4, data width in bits; two's complement; fixed at 4 for the current comparator.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has data.
- in_data  input  W  signed value to load.
- in_ready  output  1  controller accepts data.
- desc  input  1  sort order: 0 ascending, 1 descending; sampled on the first load handshake of a burst.
- cmp_a  output  W  comparator operand A.
- cmp_b  output  W  comparator operand B.
- cmp_en  output  1  operands valid (SORT state).
- cmp_gt  input  1  comparator result, A>B.
- cmp_eq  input  1  comparator result, A==B.
- cmp_lt  input  1  comparator result, A<B.
- out_valid  output  1  sorted data available.
- out_data  output  W  sorted value.
- out_ready  input  1  consumer accepts.
- done  output  1  one-cycle pulse on the final output handshake.
- cmp_err  output  1  sticky error: comparator result not one-hot.

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD; mem[0..N-1]=0; counters=0.
  - in_ready=1 after release; out_valid=0; done=0; cmp_en=0; cmp_err=0; cmp_a=cmp_b=0; desc latch=0.
  - Reset mid-operation aborts the burst with no output.
- States: LOAD -> SORT -> DRAIN -> LOAD.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready writes mem[cnt]. desc is latched on cnt=0.
  - On the N-th handshake, move to SORT next cycle. in_ready=0 from that cycle.
- SORT:
  - cmp_en=1. Pass p=0..N-2; index j=0..N-2-p.
  - cmp_a=mem[j] and cmp_b=mem[j+1], driven combinationally from the registered j.
  - At the clock edge, swap mem[j] and mem[j+1] when (desc=0 & cmp_gt) or (desc=1 & cmp_lt).
  - cmp_eq never swaps, so the sort is stable.
  - One compare per cycle. A full sort takes exactly N(N-1)/2 cycles (6 for N=4), then moves to DRAIN.
- Bad comparator result (not exactly one of gt/eq/lt high while cmp_en):
  - No swap; cmp_err set.
  - cmp_err is cleared only by reset; sequencing continues.
- DRAIN:
  - out_valid=1; out_data=mem[k], k=0..N-1.
  - k advances on out_valid&out_ready. out_data is held stable while out_ready=0.
  - On the handshake with k=N-1: done=1 for that cycle; next state LOAD, out_valid=0, in_ready=1.
- Back-to-back: the first load of the next burst is accepted the cycle after done.
- in_valid outside LOAD is ignored. out_ready outside DRAIN is ignored.
- Signed ordering: -8 is the minimum and 7 the maximum, as decided by the comparator. The controller performs no arithmetic on the data.

Optional Feature:
- Macro: CMP_SORT_EARLY_EXIT_EN.
- Defined:
  - A per-pass swap flag is tracked.
  - If a pass completes with no swap, go to DRAIN immediately after that pass's last compare.
  - A sorted N=4 burst takes 3 SORT cycles.
- Undefined: always exactly N(N-1)/2 SORT cycles regardless of data.

Test Plan:
- Load 3,-2,7,-8 with desc=0, out_ready=1 -> out 1000,1110,0011,0111 (-8,-2,3,7); SORT lasts exactly 6 cycles; done pulses once.
- Same data with desc=1 -> out 7,3,-2,-8.
- Load -8,-1,0,7 with desc=0 -> SORT lasts 3 cycles with CMP_SORT_EARLY_EXIT_EN, 6 without; output unchanged order.
- Load 5,5,-1,-1 with out_ready toggling 1,0,0,1,... -> out -1,-1,5,5; out_data held while stalled; no duplicates or drops.
- Assert rst_n=0 for one cycle during SORT cycle 3 -> all outputs at reset values immediately; new burst 1,0,2,-3 -> -3,0,1,2.
- Force cmp_gt=cmp_lt=1 for one SORT cycle -> cmp_err=1 and stays set; no swap on that cycle; burst still drains N values.
